// File: rtl/ahb_dec_pkg.sv
// Shared definitions for the AHB-Lite decoder/mux and its default slave.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ahb_dec_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP codes
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default-slave state
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // System memory map: five slaves decoded on HADDR[31:27].
    // Entry i lives at [i*5 +: 5]; slave 0 is region 0 (boot/ROM).
    localparam int unsigned DEF_NUM_SLV   = 5;
    localparam int unsigned DEF_DEC_BITS  = 5;
    localparam int unsigned DEF_REMAP_SLV = 3;
    localparam logic [DEF_NUM_SLV*DEF_DEC_BITS-1:0] DEF_SLV_MATCH =
        {5'b01010, 5'b01000, 5'b00110, 5'b00100, 5'b00000};

endpackage

// File: rtl/ahb_default_slave.sv
// AHB-Lite default slave: two-cycle ERROR for NONSEQ/SEQ to unmapped space,
// zero-wait OKAY otherwise. Latency: response starts the edge after capture.
// Backpressure: inserts one wait state (ERR1) per error; honours hready.
// Ports: clk/reset (sync, active-high); hready = muxed bus ready;
//   hsel_default/htrans = address phase; hreadyout_d/hresp_d = response.
module ahb_default_slave
    import ahb_dec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hready,
    input  logic       hsel_default,
    input  logic [1:0] htrans,
    output logic       hreadyout_d,
    output logic       hresp_d
);

    ds_state_t state;
    logic      xfer;
    logic      capture;

    // Only real transfers (NONSEQ/SEQ) earn an ERROR
    assign xfer    = (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
    assign capture = hready && hsel_default && xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DS_IDLE;
        end else begin
            case (state)
                DS_IDLE: state <= capture ? DS_ERR1 : DS_IDLE;
                DS_ERR1: state <= DS_ERR2;
                DS_ERR2: state <= capture ? DS_ERR1 : DS_IDLE;
                default: state <= DS_IDLE;
            endcase
        end
    end

    // ERR1 stalls with ERROR, ERR2 completes with ERROR
    assign hreadyout_d = (state != DS_ERR1);
    assign hresp_d     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder + slave response mux with built-in default slave.
// Latency: decode 0 cycles; response mux 0 cycles; data-phase select 1 edge.
// Backpressure: data-phase select holds while HREADY=0; HSEL keeps tracking.
// Ports: HCLK/HRESET (sync, active-high); HADDR/HTRANS/REMAP address phase;
//   HSEL/HSELDefault one-hot selects; HRDATA_S/HREADYOUT_S/HRESP_S slave
//   responses; HRDATA/HREADY/HRESP muxed back to master (HREADY to slaves).
module ahb_decoder_mux
    import ahb_dec_pkg::*;
#(
    parameter int unsigned NUM_SLV   = DEF_NUM_SLV,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEC_BITS  = DEF_DEC_BITS,
    parameter logic [NUM_SLV*DEC_BITS-1:0] SLV_MATCH = DEF_SLV_MATCH,
    parameter int unsigned REMAP_SLV = DEF_REMAP_SLV
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      REMAP,
    output logic [NUM_SLV-1:0]        HSEL,
    output logic                      HSELDefault,
    input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLV-1:0]        HREADYOUT_S,
    input  logic [NUM_SLV-1:0]        HRESP_S,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADY,
    output logic                      HRESP
);

    // Default entry sits at the top bit of the data-phase select
    localparam logic [NUM_SLV:0] DSEL_DEF = {1'b1, {NUM_SLV{1'b0}}};

    logic [DEC_BITS-1:0] field;
    logic [NUM_SLV-1:0]  hsel_dec;
    logic                hit;
    logic [NUM_SLV:0]    dsel;
    logic                hreadyout_d;
    logic                hresp_d;
    logic                unused_addr;

    assign field       = HADDR[31 -: DEC_BITS];
    assign unused_addr = &{1'b0, HADDR[31-DEC_BITS:0]};

    // Address decode: lowest matching entry wins, remap overrides region 0
    always_comb begin
        hsel_dec = '0;
        hit      = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!hit && (SLV_MATCH[i*DEC_BITS +: DEC_BITS] == field)) begin
                hsel_dec[i] = 1'b1;
                hit         = 1'b1;
            end
        end
        if (REMAP && (field == '0)) begin
            hsel_dec            = '0;
            hsel_dec[REMAP_SLV] = 1'b1;
            hit                 = 1'b1;
        end
        HSEL        = HRESET ? '0 : hsel_dec;
        HSELDefault = HRESET | ~hit;
    end

    // Data-phase select advances only when the current data phase completes
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel <= DSEL_DEF;
        end else if (HREADY) begin
            dsel <= {HSELDefault, HSEL};
        end
    end

    ahb_default_slave u_default_slave (
        .clk          (HCLK),
        .reset        (HRESET),
        .hready       (HREADY),
        .hsel_default (HSELDefault),
        .htrans       (HTRANS),
        .hreadyout_d  (hreadyout_d),
        .hresp_d      (hresp_d)
    );

    // Response mux; dsel is one-hot so at most one branch fires
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b0;
        HRESP  = HRESP_OKAY;
        if (dsel[NUM_SLV]) begin
            HREADY = hreadyout_d;
            HRESP  = hresp_d;
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel[i]) begin
                HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: scoreboard of expected read
// responses pushed at address phase, popped when the data phase completes.
// Direct checks cover address decode, wait states and the error sequence.
module tb_ahb_decoder_mux;
    import ahb_dec_pkg::*;

    localparam int NS = 5;
    localparam int DW = 32;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             REMAP;
    logic [NS-1:0]    HSEL;
    logic             HSELDefault;
    logic [NS*DW-1:0] HRDATA_S;
    logic [NS-1:0]    HREADYOUT_S;
    logic [NS-1:0]    HRESP_S;
    logic [DW-1:0]    HRDATA;
    logic             HREADY;
    logic             HRESP;

    ahb_decoder_mux dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .REMAP       (REMAP),
        .HSEL        (HSEL),
        .HSELDefault (HSELDefault),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] rdata, input logic resp);
        exp_t e;
        e.tag   = tag;
        e.rdata = rdata;
        e.resp  = resp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] slv_data(input int i);
        return 32'hA5A5_0000 + i;
    endfunction

    // Drive after the rising edge, sample on the falling edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    // Data-phase tracking from the bus protocol itself
    logic dp_pend = 1'b0;
    int   dp_wait = 0;

    always @(posedge HCLK) begin
        if (HRESET)      dp_pend <= 1'b0;
        else if (HREADY) dp_pend <= HTRANS[1];
    end

    always @(negedge HCLK) begin
        if (dp_pend && !HRESET) begin
            if (HREADY) begin
                dp_wait <= 0;
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_data"}, HRDATA, e.rdata);
                    check({e.tag, "_resp"}, {31'd0, HRESP}, {31'd0, e.resp});
                end
            end else begin
                dp_wait <= dp_wait + 1;
                if (dp_wait > 20) check("dp_timeout", {31'd0, HREADY}, 32'd1);
            end
        end
    end

    initial begin
        HRESET      = 1'b1;
        HADDR       = 32'h2000_0000;
        HTRANS      = HTRANS_IDLE;
        REMAP       = 1'b0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = slv_data(i);

        // Reset
        repeat (2) tick();
        sample();
        check("rst_hsel",  {27'd0, HSEL}, 32'd0);
        check("rst_hdef",  {31'd0, HSELDefault}, 32'd1);
        check("rst_ready", {31'd0, HREADY}, 32'd1);
        check("rst_resp",  {31'd0, HRESP}, 32'd0);
        check("rst_rdata", HRDATA, 32'd0);

        // Mapped read to slave 1 with two wait states
        tick();
        HRESET = 1'b0;
        HADDR  = 32'h2000_0010;
        HTRANS = HTRANS_NONSEQ;
        HRDATA_S[1*DW +: DW] = 32'hDEAD_BEEF;
        push("rd_s1", 32'hDEAD_BEEF, 1'b0);
        sample();
        check("s1_hsel", {27'd0, HSEL}, 32'b00010);
        check("s1_hdef", {31'd0, HSELDefault}, 32'd0);
        tick();
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        HREADYOUT_S[1] = 1'b0;
        sample();
        check("s1_wait1", {31'd0, HREADY}, 32'd0);
        tick();
        sample();
        check("s1_wait2", {31'd0, HREADY}, 32'd0);
        tick();
        HREADYOUT_S[1] = 1'b1;
        sample();
        check("s1_done", {31'd0, HREADY}, 32'd1);

        // Unmapped NONSEQ -> two-cycle ERROR then OKAY
        tick();
        HADDR  = 32'h1000_0000;
        HTRANS = HTRANS_NONSEQ;
        push("err_ns", 32'd0, 1'b1);
        sample();
        check("un_hdef", {31'd0, HSELDefault}, 32'd1);
        check("un_hsel", {27'd0, HSEL}, 32'd0);
        tick();
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        sample();
        check("err1_ready", {31'd0, HREADY}, 32'd0);
        check("err1_resp",  {31'd0, HRESP}, 32'd1);
        tick();
        sample();
        check("err2_ready", {31'd0, HREADY}, 32'd1);
        check("err2_resp",  {31'd0, HRESP}, 32'd1);
        tick();
        sample();
        check("post_ready", {31'd0, HREADY}, 32'd1);
        check("post_resp",  {31'd0, HRESP}, 32'd0);

        // Unmapped IDLE gets zero-wait OKAY
        tick();
        HADDR  = 32'h1000_0000;
        HTRANS = HTRANS_IDLE;
        sample();
        check("uidle_hdef", {31'd0, HSELDefault}, 32'd1);
        tick();
        HTRANS = HTRANS_NONSEQ;
        push("err_a", 32'd0, 1'b1);
        sample();
        check("uidle_ready", {31'd0, HREADY}, 32'd1);
        check("uidle_resp",  {31'd0, HRESP}, 32'd0);

        // Back-to-back unmapped: second NONSEQ accepted in ERR2
        tick();
        HADDR = 32'h1800_0000;
        push("err_b", 32'd0, 1'b1);
        sample();
        check("b2b_e1_ready", {31'd0, HREADY}, 32'd0);
        check("b2b_hdef",     {31'd0, HSELDefault}, 32'd1);
        tick();
        sample();
        check("b2b_e2_ready", {31'd0, HREADY}, 32'd1);
        tick();
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        sample();
        check("b2b_re_err1", {31'd0, HREADY}, 32'd0);
        check("b2b_re_resp", {31'd0, HRESP}, 32'd1);
        tick();
        sample();
        check("b2b_fin_ready", {31'd0, HREADY}, 32'd1);

        // Remap: region 0 goes to slave 3; change affects later phases only
        tick();
        REMAP  = 1'b1;
        HADDR  = 32'h0000_0100;
        HTRANS = HTRANS_NONSEQ;
        push("remap_rd", slv_data(3), 1'b0);
        sample();
        check("remap_hsel", {27'd0, HSEL}, 32'b01000);
        tick();
        REMAP  = 1'b0;
        HTRANS = HTRANS_IDLE;
        sample();
        check("noremap_hsel", {27'd0, HSEL}, 32'b00001);

        // Pipelined address to slave 4 while slave 0 data phase stalls
        tick();
        HADDR  = 32'h0000_0000;
        HTRANS = HTRANS_NONSEQ;
        push("s0_rd", slv_data(0), 1'b0);
        tick();
        HADDR  = 32'h5000_0000;
        push("s4_rd", slv_data(4), 1'b0);
        HREADYOUT_S[0] = 1'b0;
        sample();
        check("pipe_hsel",  {27'd0, HSEL}, 32'b10000);
        check("pipe_stall", {31'd0, HREADY}, 32'd0);
        tick();
        sample();
        check("pipe_hold", HRDATA, slv_data(0));
        tick();
        HREADYOUT_S[0] = 1'b1;
        sample();
        tick();
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        sample();

        // Reset pulsed during ERR1: no ERR2 afterwards
        tick();
        HADDR  = 32'h1000_0000;
        HTRANS = HTRANS_NONSEQ;
        tick();
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        HRESET = 1'b1;
        sample();
        check("xr_err1",  {31'd0, HREADY}, 32'd0);
        check("xr_hsel",  {27'd0, HSEL}, 32'd0);
        check("xr_hdef",  {31'd0, HSELDefault}, 32'd1);
        tick();
        HRESET = 1'b0;
        sample();
        check("xr_ready", {31'd0, HREADY}, 32'd1);
        check("xr_resp",  {31'd0, HRESP}, 32'd0);
        tick();
        sample();
        check("xr_resp2", {31'd0, HRESP}, 32'd0);

        tick();
        sample();
        check("sb_drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
